// File: rtl/elevator_scan_scheduler.sv
// SCAN (collective) scheduler and car sequencer for a single elevator car.
// Latches call buttons into a pending mask and times travel and door dwell internally.
//
// state     | meaning
// IDLE      | parked with doors closed, waiting for a pending call
// MOVE_UP   | travelling toward a higher floor
// MOVE_DOWN | travelling toward a lower floor
// DOOR_OPEN | stopped with doors open, dwell timer running
module elevator_scan_scheduler #(
    parameter int NUM_FLOORS    = 5,
    parameter int FLOOR_W       = 3,
    parameter int TRAVEL_CYCLES = 2,
    parameter int DOOR_CYCLES   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_FLOORS-1:0] call_btn,
    input  logic                  door_hold,
    output logic [FLOOR_W-1:0]    cur_floor,
    output logic                  dir_up,
    output logic                  moving,
    output logic                  door_open,
    output logic                  arrive,
    output logic [NUM_FLOORS-1:0] pending
);

    localparam int TMR_MAX = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES - 1 : DOOR_CYCLES - 1;
    localparam int TMR_W   = (TMR_MAX < 1) ? 1 : $clog2(TMR_MAX + 1);
    localparam logic [TMR_W-1:0] TRAVEL_LOAD = TMR_W'(TRAVEL_CYCLES - 1);
    localparam logic [TMR_W-1:0] DOOR_LOAD   = TMR_W'(DOOR_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN} state_t;

    state_t                  state_q, state_d;
    logic [FLOOR_W-1:0]      cur_floor_q, cur_floor_d;
    logic                    dir_up_q, dir_up_d;
    logic                    moving_q, moving_d;
    logic                    door_open_q, door_open_d;
    logic                    arrive_q, arrive_d;
    logic [NUM_FLOORS-1:0]   pending_q, pending_d;
    logic [TMR_W-1:0]        tmr_q, tmr_d;
    logic [NUM_FLOORS-1:0]   clr;
    logic [FLOOR_W-1:0]      nf;
    logic                    here, above, below;

    function automatic logic bit_at(input logic [NUM_FLOORS-1:0] m, input logic [FLOOR_W-1:0] f);
        bit_at = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++)
            if (m[i] && (FLOOR_W'(i) == f)) bit_at = 1'b1;
    endfunction

    function automatic logic any_above(input logic [NUM_FLOORS-1:0] m, input logic [FLOOR_W-1:0] f);
        any_above = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++)
            if (m[i] && (FLOOR_W'(i) > f)) any_above = 1'b1;
    endfunction

    function automatic logic any_below(input logic [NUM_FLOORS-1:0] m, input logic [FLOOR_W-1:0] f);
        any_below = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++)
            if (m[i] && (FLOOR_W'(i) < f)) any_below = 1'b1;
    endfunction

    always_comb begin
        state_d     = state_q;
        cur_floor_d = cur_floor_q;
        dir_up_d    = dir_up_q;
        tmr_d       = tmr_q;
        arrive_d    = 1'b0;
        here        = bit_at(pending_q, cur_floor_q);
        above       = any_above(pending_q, cur_floor_q);
        below       = any_below(pending_q, cur_floor_q);
        nf          = (state_q == MOVE_UP) ? cur_floor_q + FLOOR_W'(1) : cur_floor_q - FLOOR_W'(1);

        case (state_q)
            IDLE: begin
                if (here) begin
                    state_d = DOOR_OPEN;
                    tmr_d   = DOOR_LOAD;
                end else if (above && (dir_up_q || !below)) begin
                    state_d  = MOVE_UP;
                    dir_up_d = 1'b1;
                    tmr_d    = TRAVEL_LOAD;
                end else if (below) begin
                    state_d  = MOVE_DOWN;
                    dir_up_d = 1'b0;
                    tmr_d    = TRAVEL_LOAD;
                end
            end
            MOVE_UP, MOVE_DOWN: begin
                if (tmr_q != '0) begin
                    tmr_d = tmr_q - TMR_W'(1);
                end else begin
                    cur_floor_d = nf;
                    arrive_d    = 1'b1;
                    tmr_d       = TRAVEL_LOAD;
                    if (bit_at(pending_q, nf)) begin
                        state_d = DOOR_OPEN;
                        tmr_d   = DOOR_LOAD;
                    end else if (!((state_q == MOVE_UP) ? any_above(pending_q, nf)
                                                        : any_below(pending_q, nf))) begin
                        state_d = IDLE;
                        tmr_d   = '0;
                    end
                end
            end
            DOOR_OPEN: begin
                // a press at this floor is absorbed and counts like door_hold
                if (door_hold || bit_at(call_btn, cur_floor_q)) begin
                    tmr_d = DOOR_LOAD;
                end else if (tmr_q != '0) begin
                    tmr_d = tmr_q - TMR_W'(1);
                end else if (dir_up_q ? above : below) begin
                    state_d = dir_up_q ? MOVE_UP : MOVE_DOWN;
                    tmr_d   = TRAVEL_LOAD;
                end else if (dir_up_q ? below : above) begin
                    state_d  = dir_up_q ? MOVE_DOWN : MOVE_UP;
                    dir_up_d = !dir_up_q;
                    tmr_d    = TRAVEL_LOAD;
                end else begin
                    state_d = IDLE;
                    tmr_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                tmr_d   = '0;
            end
        endcase

        for (int i = 0; i < NUM_FLOORS; i++)
            clr[i] = ((state_q == DOOR_OPEN) || (state_d == DOOR_OPEN)) && (cur_floor_d == FLOOR_W'(i));
        pending_d   = (pending_q | call_btn) & ~clr;
        moving_d    = (state_d == MOVE_UP) || (state_d == MOVE_DOWN);
        door_open_d = (state_d == DOOR_OPEN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cur_floor_q <= '0;
            dir_up_q    <= 1'b1;
            moving_q    <= 1'b0;
            door_open_q <= 1'b0;
            arrive_q    <= 1'b0;
            pending_q   <= '0;
            tmr_q       <= '0;
        end else begin
            state_q     <= state_d;
            cur_floor_q <= cur_floor_d;
            dir_up_q    <= dir_up_d;
            moving_q    <= moving_d;
            door_open_q <= door_open_d;
            arrive_q    <= arrive_d;
            pending_q   <= pending_d;
            tmr_q       <= tmr_d;
        end
    end

    assign cur_floor = cur_floor_q;
    assign dir_up    = dir_up_q;
    assign moving    = moving_q;
    assign door_open = door_open_q;
    assign arrive    = arrive_q;
    assign pending   = pending_q;

endmodule

// File: tb/tb_elevator_scan_scheduler.sv
// Directed bench for elevator_scan_scheduler: timing of a single trip, SCAN ordering,
// door hold, absorbed calls, async reset and an all-floor sweep.
module tb_elevator_scan_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] call_btn;
    logic       door_hold;
    logic [2:0] cur_floor;
    logic       dir_up;
    logic       moving;
    logic       door_open;
    logic       arrive;
    logic [4:0] pending;

    int checks = 0;
    int errors = 0;

    elevator_scan_scheduler #(
        .NUM_FLOORS(5), .FLOOR_W(3), .TRAVEL_CYCLES(2), .DOOR_CYCLES(4)
    ) dut (
        .clk(clk), .rst(rst), .call_btn(call_btn), .door_hold(door_hold),
        .cur_floor(cur_floor), .dir_up(dir_up), .moving(moving),
        .door_open(door_open), .arrive(arrive), .pending(pending)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic press(input logic [4:0] b);
        call_btn = b;
        step();
        call_btn = 5'b00000;
    endtask

    task automatic wait_floor(input string tag, input int f);
        for (int i = 0; i < 100 && int'(cur_floor) != f; i++) step();
        chk(tag, int'(cur_floor), f);
    endtask

    task automatic wait_open(input string tag, input int f, input int arrives);
        int n = 0;
        for (int i = 0; i < 200 && !door_open; i++) begin
            step();
            if (arrive) n++;
        end
        chk({tag, "_open"}, int'(door_open), 1);
        chk({tag, "_floor"}, int'(cur_floor), f);
        chk({tag, "_arrives"}, n, arrives);
    endtask

    task automatic wait_close(input string tag, input int dwell);
        int n = 0;
        for (int i = 0; i < 200 && door_open; i++) begin
            n++;
            step();
        end
        chk({tag, "_closed"}, int'(door_open), 0);
        chk({tag, "_dwell"}, n, dwell);
    endtask

    task automatic run_stop(input string tag, input int f, input int arrives);
        wait_open(tag, f, arrives);
        wait_close(tag, 4);
    endtask

    initial begin
        rst       = 1'b1;
        call_btn  = 5'b00000;
        door_hold = 1'b0;
        step();
        step();
        chk("rst_floor", int'(cur_floor), 0);
        chk("rst_dir", int'(dir_up), 1);
        chk("rst_pending", int'(pending), 0);
        chk("rst_door", int'(door_open), 0);
        rst = 1'b0;
        step();

        // single trip 0 -> 3, cycle-exact against edge k
        press(5'b01000);
        chk("t2_pend_k", int'(pending), 'b01000);
        chk("t2_move_k", int'(moving), 0);
        for (int c = 1; c <= 11; c++) begin
            int ef;
            step();
            ef = (c < 3) ? 0 : (c < 5) ? 1 : (c < 7) ? 2 : 3;
            chk($sformatf("t2_floor_%0d", c), int'(cur_floor), ef);
            chk($sformatf("t2_moving_%0d", c), int'(moving), (c >= 1 && c <= 6) ? 1 : 0);
            chk($sformatf("t2_door_%0d", c), int'(door_open), (c >= 7 && c <= 10) ? 1 : 0);
            chk($sformatf("t2_arrive_%0d", c), int'(arrive), (c == 3 || c == 5 || c == 7) ? 1 : 0);
        end
        chk("t2_pend_end", int'(pending), 0);

        // async reset while moving down past floor 2
        press(5'b00001);
        wait_floor("t1_at2", 2);
        chk("t1_midmove", int'(moving), 1);
        chk("t1_dir", int'(dir_up), 0);
        #2 rst = 1'b1;
        #1;
        chk("t1_async_floor", int'(cur_floor), 0);
        chk("t1_async_pend", int'(pending), 0);
        chk("t1_async_dir", int'(dir_up), 1);
        chk("t1_async_moving", int'(moving), 0);
        chk("t1_async_door", int'(door_open), 0);
        step();
        chk("t1_held_floor", int'(cur_floor), 0);
        rst = 1'b0;
        step();
        chk("t1_idle", int'(moving), 0);

        // SCAN order: going up at 2 with calls at 0 and 4
        press(5'b10000);
        wait_floor("t3_at1", 1);
        press(5'b00001);
        wait_floor("t3_at2", 2);
        chk("t3_pend", int'(pending), 'b10001);
        chk("t3_dir_up", int'(dir_up), 1);
        chk("t3_moving", int'(moving), 1);
        run_stop("t3_stop4", 4, 2);
        chk("t3_rev_dir", int'(dir_up), 0);
        run_stop("t3_stop0", 0, 4);
        chk("t3_pend_end", int'(pending), 0);
        chk("t3_idle", int'(moving), 0);

        // door hold at floor 1
        press(5'b00010);
        wait_open("t4", 1, 1);
        door_hold = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk($sformatf("t4_held_%0d", i), int'(door_open), 1);
        end
        door_hold = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            step();
            chk($sformatf("t4_rel_%0d", i), int'(door_open), 1);
        end
        step();
        chk("t4_closed", int'(door_open), 0);

        // absorbed call at floor 3 restarts dwell
        press(5'b01000);
        wait_open("t5", 3, 2);
        step();
        step();
        press(5'b01000);
        chk("t5_absorbed", int'(pending), 0);
        chk("t5_open_e3", int'(door_open), 1);
        for (int i = 1; i <= 3; i++) begin
            step();
            chk($sformatf("t5_open_%0d", i), int'(door_open), 1);
        end
        step();
        chk("t5_closed", int'(door_open), 0);

        // all floors from 0
        press(5'b00001);
        run_stop("t6_home", 0, 3);
        chk("t6_home_dir", int'(dir_up), 0);
        press(5'b11111);
        chk("t6_pend_all", int'(pending), 'b11111);
        run_stop("t6_s0", 0, 0);
        run_stop("t6_s1", 1, 1);
        run_stop("t6_s2", 2, 1);
        run_stop("t6_s3", 3, 1);
        run_stop("t6_s4", 4, 1);
        step();
        step();
        chk("t6_pend_end", int'(pending), 0);
        chk("t6_floor_end", int'(cur_floor), 4);
        chk("t6_idle_moving", int'(moving), 0);
        chk("t6_idle_door", int'(door_open), 0);
        chk("t6_dir_end", int'(dir_up), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
